// File: rtl/opm_pkg.sv
// Shared definitions for the opm pulse generator and its run-time sequencer.
// State and fault-code encodings are visible on debug ports, so the values are fixed.
package opm_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StRamp  = 3'd2,
        StRun   = 3'd3,
        StDrain = 3'd4,
        StFault = 3'd5
    } seq_state_e;

    typedef enum logic [1:0] {
        FltNone = 2'b00,
        FltExt  = 2'b01,
        FltWdog = 2'b10
    } flt_code_e;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned TIME_60US = 2400;

endpackage

// File: rtl/opm_ramp_step.sv
// Combinational saturating step of cur toward tgt by at most step; step == 0 jumps to tgt.
// Never overshoots and never wraps, in either direction.
module opm_ramp_step (
    input  logic [15:0] cur,
    input  logic [15:0] tgt,
    input  logic [15:0] step,
    output logic [15:0] nxt,
    output logic        at_tgt
);

    logic        up;
    logic [16:0] diff;

    always_comb begin
        up   = (tgt >= cur);
        diff = up ? ({1'b0, tgt} - {1'b0, cur}) : ({1'b0, cur} - {1'b0, tgt});
        // diff > step guarantees cur +/- step stays strictly between cur and tgt
        if ((step == 16'd0) || (diff <= {1'b0, step})) begin
            nxt = tgt;
        end else if (up) begin
            nxt = cur + step;
        end else begin
            nxt = cur - step;
        end
        at_tgt = (nxt == tgt);
    end

endmodule

// File: rtl/opm_seq.sv
// Run-time sequencer for opm: start/stop sequencing, soft-start delay ramp,
// sig_in loss watchdog and latched fault shutdown.
module opm_seq
    import opm_pkg::*;
#(
    parameter logic [23:0] WDOG_CYC = 24'd80000,
    parameter int unsigned SYNC_STG = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        fault_in,
    input  logic        flt_clr,
    input  logic        sig_in,
    input  logic [15:0] tgt_timer,
    input  logic [15:0] tgt_delay,
    input  logic [15:0] init_delay,
    input  logic [15:0] step,
    output logic [7:0]  ctrl,
    output logic [15:0] timer_val,
    output logic [15:0] delay_time,
    output logic        ramp_done,
    output logic        flt,
    output logic [1:0]  flt_code,
    output logic [2:0]  state
);

    seq_state_e          state_q, state_d;
    flt_code_e           code_q, code_d;
    logic [SYNC_STG-1:0] sync_q;
    logic [1:0]          hist_q;
    logic                rise, fall, rise_q;
    logic [23:0]         wdog_q, wdog_d;
    logic                wdog_run, wdog_hit;
    logic [15:0]         timer_q, timer_d;
    logic [15:0]         delay_q, delay_d;
    logic [15:0]         step_nxt;
    logic                step_at_tgt;

    // Same synchroniser depth and history alignment as opm's own edge detector.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 2'b00;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STG-2:0], sig_in};
            hist_q <= {hist_q[0], sync_q[SYNC_STG-1]};
            rise_q <= rise;
        end
    end

    assign rise = (hist_q == 2'b01);
    assign fall = (hist_q == 2'b10);

    always_comb begin
        wdog_run = (state_q == StRamp) || (state_q == StRun) || (state_q == StDrain);
        wdog_hit = wdog_run && !rise && !fall && (wdog_q == WDOG_CYC - 24'd1);
        if (!wdog_run || rise || fall) begin
            wdog_d = 24'd0;
        end else begin
            wdog_d = wdog_q + 24'd1;
        end
    end

    opm_ramp_step u_delay_step (
        .cur    (delay_q),
        .tgt    (tgt_delay),
        .step   (step),
        .nxt    (step_nxt),
        .at_tgt (step_at_tgt)
    );

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        timer_d = timer_q;
        delay_d = delay_q;
        unique case (state_q)
            StIdle: begin
                if (fault_in) begin
                    state_d = StFault;
                    code_d  = FltExt;
                end else if (start && !stop) begin
                    state_d = StArm;
                    timer_d = tgt_timer;
                    delay_d = init_delay;
                end
            end
            StArm: begin
                if (fault_in) begin
                    state_d = StFault;
                    code_d  = FltExt;
                end else if (stop) begin
                    state_d = StIdle;
                end else if (rise) begin
                    state_d = StRamp;
                end
            end
            StRamp, StRun: begin
                if (fault_in) begin
                    state_d = StFault;
                    code_d  = FltExt;
                end else if (wdog_hit) begin
                    state_d = StFault;
                    code_d  = FltWdog;
                end else if (stop) begin
                    state_d = StDrain;
                end else if (rise_q) begin
                    // Update slot: one cycle after the detected rise, never the edge cycle.
                    timer_d = tgt_timer;
                    delay_d = step_nxt;
                    if ((state_q == StRamp) && step_at_tgt) begin
                        state_d = StRun;
                    end
                end
            end
            StDrain: begin
                if (fault_in) begin
                    state_d = StFault;
                    code_d  = FltExt;
                end else if (wdog_hit) begin
                    state_d = StFault;
                    code_d  = FltWdog;
                end else if (fall) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                if (flt_clr && !fault_in && !start) begin
                    state_d = StIdle;
                    code_d  = FltNone;
                end
            end
            default: begin
                state_d = StIdle;
                code_d  = FltNone;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            code_q  <= FltNone;
            wdog_q  <= 24'd0;
            timer_q <= 16'd0;
            delay_q <= 16'd0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            wdog_q  <= wdog_d;
            timer_q <= timer_d;
            delay_q <= delay_d;
        end
    end

    // Enable is decoded from the registered state so a fault drops it in the cycle it is taken.
    always_comb begin
        ctrl          = 8'h00;
        ctrl[CTRL_EN] = (state_q == StRamp) || (state_q == StRun) || (state_q == StDrain);
        timer_val     = timer_q;
        delay_time    = delay_q;
        ramp_done     = (state_q == StRun) && (delay_q == tgt_delay);
        flt           = (state_q == StFault);
        flt_code      = code_q;
        state         = state_q;
    end

endmodule

// File: tb/tb_opm_seq.sv
// Self-checking bench for opm_seq: directed scenarios plus randomized ramps
// checked against a plain-arithmetic model of the delay_time stepping rule.
module tb_opm_seq;

    localparam int W = 1000;

    logic        clk;
    logic        rst;
    logic        start, stop, fault_in, flt_clr, sig_in;
    logic [15:0] tgt_timer, tgt_delay, init_delay, step;
    logic [7:0]  ctrl;
    logic [15:0] timer_val, delay_time;
    logic        ramp_done, flt;
    logic [1:0]  flt_code;
    logic [2:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    int m_delay;
    int m_timer;
    bit m_run;

    opm_seq #(
        .WDOG_CYC (24'd1000),
        .SYNC_STG (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .fault_in   (fault_in),
        .flt_clr    (flt_clr),
        .sig_in     (sig_in),
        .tgt_timer  (tgt_timer),
        .tgt_delay  (tgt_delay),
        .init_delay (init_delay),
        .step       (step),
        .ctrl       (ctrl),
        .timer_val  (timer_val),
        .delay_time (delay_time),
        .ramp_done  (ramp_done),
        .flt        (flt),
        .flt_code   (flt_code),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: move by at most stp toward tgt, landing exactly on tgt when close.
    function automatic int step_toward(input int cur, input int tgt, input int stp);
        int d;
        d = tgt - cur;
        if (stp == 0 || (d <= stp && d >= -stp)) return tgt;
        return (d > 0) ? cur + stp : cur - stp;
    endfunction

    function automatic int updates_needed(input int cur, input int tgt, input int stp);
        int n;
        int v;
        n = 0;
        v = cur;
        while (v != tgt) begin
            v = step_toward(v, tgt, stp);
            n++;
        end
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        start = 0; stop = 0; fault_in = 0; flt_clr = 0; sig_in = 0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic arm(input int init, input int tgt, input int stp, input int tmr);
        init_delay = 16'(init);
        tgt_delay  = 16'(tgt);
        step       = 16'(stp);
        tgt_timer  = 16'(tmr);
        start = 1'b1;
        tick();
        start = 1'b0;
        m_delay = init;
        m_timer = tmr;
        m_run   = 1'b0;
        n_checks++;
        if (state !== 3'd1 || delay_time !== 16'(init) || timer_val !== 16'(tmr) || ctrl !== 8'h00) begin
            n_errors++;
            $display("FAIL arm: state %0d delay %0d timer %0d ctrl %0h, want 1 %0d %0d 00",
                     state, delay_time, timer_val, ctrl, init, tmr);
        end
    endtask

    // Drives full sig_in periods; the update lands 5 samples after each raw rise
    // (2 sync flops, 1 history flop, then the update slot).
    task automatic run_ramp(input int periods, input int half, input bit arming);
        for (int p = 0; p < periods; p++) begin
            sig_in = 1'b1;
            for (int t = 1; t <= half; t++) begin
                tick();
                if (arming && p == 0 && t == 3) begin
                    n_checks++;
                    if (ctrl !== 8'h00) begin
                        n_errors++;
                        $display("FAIL en_early: ctrl %0h want 00", ctrl);
                    end
                end
                if (t == 4) begin
                    n_checks++;
                    if (ctrl !== 8'h01 || delay_time !== 16'(m_delay)) begin
                        n_errors++;
                        $display("FAIL pre_slot: ctrl %0h delay %0d want 01 %0d",
                                 ctrl, delay_time, m_delay);
                    end
                end
                if (t == 5) begin
                    m_delay = step_toward(m_delay, int'(tgt_delay), int'(step));
                    m_timer = int'(tgt_timer);
                    if (m_delay == int'(tgt_delay)) m_run = 1'b1;
                    n_checks++;
                    if (delay_time !== 16'(m_delay) || timer_val !== 16'(m_timer)) begin
                        n_errors++;
                        $display("FAIL slot_update: delay %0d timer %0d want %0d %0d",
                                 delay_time, timer_val, m_delay, m_timer);
                    end
                    n_checks++;
                    if (state !== (m_run ? 3'd3 : 3'd2) ||
                        ramp_done !== (m_run && m_delay == int'(tgt_delay))) begin
                        n_errors++;
                        $display("FAIL slot_state: state %0d ramp_done %0b want %0d %0b",
                                 state, ramp_done, m_run ? 3 : 2, m_run && m_delay == int'(tgt_delay));
                    end
                end
            end
            sig_in = 1'b0;
            repeat (half) tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ctrl !== 8'h00 || timer_val !== 16'd0 || delay_time !== 16'd0 || ramp_done !== 1'b0 ||
            flt !== 1'b0 || flt_code !== 2'b00 || state !== 3'd0) begin
            n_errors++;
            $display("FAIL reset: ctrl %0h tv %0d dt %0d rd %0b flt %0b code %0d st %0d, want all 0",
                     ctrl, timer_val, delay_time, ramp_done, flt, flt_code, state);
        end
    endtask

    task automatic test_idle_guard();
        start = 1'b1;
        stop  = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL start_and_stop: state %0d want 0", state);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_basic_ramp();
        do_reset();
        arm(100, 400, 100, 50);
        repeat (12) tick();
        n_checks++;
        if (state !== 3'd1 || ctrl !== 8'h00) begin
            n_errors++;
            $display("FAIL arm_wait: state %0d ctrl %0h want 1 00", state, ctrl);
        end
        run_ramp(4, 50, 1'b1);
        n_checks++;
        if (delay_time !== 16'd400 || ramp_done !== 1'b1 || state !== 3'd3 || timer_val !== 16'd50) begin
            n_errors++;
            $display("FAIL basic_end: delay %0d rd %0b state %0d timer %0d want 400 1 3 50",
                     delay_time, ramp_done, state, timer_val);
        end
    endtask

    task automatic test_ramp_down();
        do_reset();
        arm(500, 120, 200, 77);
        run_ramp(3, 30, 1'b1);
        n_checks++;
        if (delay_time !== 16'd120 || ramp_done !== 1'b1) begin
            n_errors++;
            $display("FAIL ramp_down_end: delay %0d rd %0b want 120 1", delay_time, ramp_done);
        end
    endtask

    task automatic test_random_ramp();
        int init, tgt, stp, half, n;
        for (int trial = 0; trial < 10; trial++) begin
            init = int'($urandom_range(0, 3000));
            tgt  = int'($urandom_range(0, 3000));
            stp  = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(50, 400));
            if (trial == 0) begin init = 16'hFFF0; tgt = 16'hFFFF; stp = 100; end
            if (trial == 1) begin init = 5;        tgt = 0;        stp = 100; end
            if (trial == 2) begin init = 16'hFF00; tgt = 0;        stp = 0;   end
            half = int'($urandom_range(8, 40));
            do_reset();
            arm(init, tgt, stp, int'($urandom_range(0, 65535)));
            n = updates_needed(init, tgt, stp);
            run_ramp(n + 2, half, 1'b1);
            // Retarget mid-RUN; the change only applies at later update slots.
            tgt = int'($urandom_range(0, 3000));
            tgt_delay = 16'(tgt);
            tgt_timer = 16'($urandom_range(0, 65535));
            n = updates_needed(m_delay, tgt, stp);
            run_ramp(n + 1, half, 1'b0);
        end
    endtask

    task automatic test_stop_drain();
        do_reset();
        arm(300, 300, 0, 40);
        run_ramp(2, 30, 1'b1);
        sig_in = 1'b1;
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n_checks++;
        if (state !== 3'd4 || ctrl !== 8'h01) begin
            n_errors++;
            $display("FAIL drain_enter: state %0d ctrl %0h want 4 01", state, ctrl);
        end
        repeat (20) tick();
        sig_in = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (ctrl !== 8'h01 || state !== 3'd4) begin
            n_errors++;
            $display("FAIL drain_hold: ctrl %0h state %0d want 01 4", ctrl, state);
        end
        tick();
        n_checks++;
        if (ctrl !== 8'h00 || state !== 3'd0) begin
            n_errors++;
            $display("FAIL drain_exit: ctrl %0h state %0d want 00 0", ctrl, state);
        end
        repeat (5) tick();
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL drain_idle: state %0d want 0", state);
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        arm(10, 20, 0, 5);
        run_ramp(2, 20, 1'b1);
        sig_in = 1'b1;
        for (int t = 1; t <= W + 4; t++) begin
            tick();
            if (t == W + 3) begin
                n_checks++;
                if (flt !== 1'b0 || state !== 3'd3) begin
                    n_errors++;
                    $display("FAIL wdog_early: flt %0b state %0d want 0 3", flt, state);
                end
            end
        end
        n_checks++;
        if (flt !== 1'b1 || flt_code !== 2'b10 || ctrl !== 8'h00 || state !== 3'd5) begin
            n_errors++;
            $display("FAIL wdog_trip: flt %0b code %0d ctrl %0h state %0d want 1 2 00 5",
                     flt, flt_code, ctrl, state);
        end
        fault_in = 1'b1;
        tick();
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        n_checks++;
        if (flt_code !== 2'b10 || state !== 3'd5) begin
            n_errors++;
            $display("FAIL first_code_kept: code %0d state %0d want 2 5", flt_code, state);
        end
        fault_in = 1'b0;
        start = 1'b1;
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        n_checks++;
        if (state !== 3'd5 || flt !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_with_start: state %0d flt %0b want 5 1", state, flt);
        end
        start = 1'b0;
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        n_checks++;
        if (state !== 3'd0 || flt !== 1'b0 || flt_code !== 2'b00) begin
            n_errors++;
            $display("FAIL clr: state %0d flt %0b code %0d want 0 0 0", state, flt, flt_code);
        end
    endtask

    task automatic test_fault_priority();
        do_reset();
        arm(0, 1000, 10, 9);
        run_ramp(2, 20, 1'b1);
        fault_in = 1'b1;
        stop     = 1'b1;
        tick();
        n_checks++;
        if (state !== 3'd5 || flt_code !== 2'b01 || ctrl !== 8'h00 || flt !== 1'b1) begin
            n_errors++;
            $display("FAIL fault_over_stop: state %0d code %0d ctrl %0h flt %0b want 5 1 00 1",
                     state, flt_code, ctrl, flt);
        end
        fault_in = 1'b0;
        stop     = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (state !== 3'd5 || flt_code !== 2'b01) begin
            n_errors++;
            $display("FAIL fault_latched: state %0d code %0d want 5 1", state, flt_code);
        end
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
        fault_in = 1'b1;
        tick();
        fault_in = 1'b0;
        n_checks++;
        if (state !== 3'd5 || flt_code !== 2'b01) begin
            n_errors++;
            $display("FAIL fault_in_idle: state %0d code %0d want 5 1", state, flt_code);
        end
        flt_clr = 1'b1;
        tick();
        flt_clr = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        arm(200, 200, 0, 33);
        run_ramp(2, 20, 1'b1);
        sig_in = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if (ctrl !== 8'h00 || timer_val !== 16'd0 || delay_time !== 16'd0 || state !== 3'd0 ||
            ramp_done !== 1'b0 || flt !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: ctrl %0h tv %0d dt %0d st %0d rd %0b flt %0b want all 0",
                     ctrl, timer_val, delay_time, state, ramp_done, flt);
        end
        sig_in = 1'b0;
        start  = 1'b1;
        repeat (2) tick();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (state !== 3'd0) begin
            n_errors++;
            $display("FAIL post_release: state %0d want 0", state);
        end
        repeat (20) tick();
        n_checks++;
        if (state !== 3'd1 || ctrl !== 8'h00) begin
            n_errors++;
            $display("FAIL rearm_wait: state %0d ctrl %0h want 1 00", state, ctrl);
        end
        sig_in = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (state !== 3'd2 || ctrl !== 8'h01) begin
            n_errors++;
            $display("FAIL rearm_rise: state %0d ctrl %0h want 2 01", state, ctrl);
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        start = 0; stop = 0; fault_in = 0; flt_clr = 0; sig_in = 0;
        tgt_timer = 0; tgt_delay = 0; init_delay = 0; step = 0;
        test_reset();
        test_idle_guard();
        test_basic_ramp();
        test_ramp_down();
        test_random_ramp();
        test_stop_drain();
        test_watchdog();
        test_fault_priority();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/opm_seq.md
Name: opm_seq

Overview:
- Run-time sequencer for the opm trigger-pulse generator; drives opm's ctrl, timer_val and delay_time.
- Provides start/stop sequencing, a soft-start ramp of delay_time, a sig_in loss watchdog and latched fault shutdown.
- Sits between the host/config registers and one opm instance; clock is 40 MHz, shared with opm.

Parameters:
- WDOG_CYC, 24'd80000, max cycles between sig_in edges while enabled (2 ms at 40 MHz); must be ≥ 3.
- SYNC_STG, 2, sig_in synchroniser depth; must equal opm's 2-stage edge detector.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; request to run (sampled in IDLE).
- stop  in  1  level; request orderly shutdown.
- fault_in  in  1  external hard fault, active-high, level.
- flt_clr  in  1  single-cycle pulse; clears latched fault.
- sig_in  in  1  same raw square wave fed to opm.
- tgt_timer  in  16  target timer_val.
- tgt_delay  in  16  target delay_time.
- init_delay  in  16  delay_time applied at arm.
- step  in  16  delay_time change per sig_in period; 0 = jump to target.
- ctrl  out  8  to opm: bit0 = enable, bits7:1 = 0.
- timer_val  out  16  to opm.
- delay_time  out  16  to opm.
- ramp_done  out  1  high while in RUN and delay_time == tgt_delay.
- flt  out  1  latched fault flag.
- flt_code  out  2  00 none, 01 fault_in, 10 watchdog.
- state  out  3  current state encoding, for debug.

Behaviour:
- Reset (rst low, async): ctrl=0, timer_val=0, delay_time=0, ramp_done=0, flt=0, flt_code=00, state=IDLE, sync chain=0, watchdog counter=0.
- Edge detect: sig_in passes through SYNC_STG flops, then a 2-bit history. rise = 01, fall = 10. Alignment is identical to opm's detection.
- Parameter update slot is the cycle after a detected rise. timer_val and delay_time change only in this slot; they are never changed in the edge cycle itself.
- States:
  - IDLE (0): ctrl[0]=0. If start=1, stop=0, flt=0 → ARM; load timer_val=tgt_timer, delay_time=init_delay.
  - ARM (1): ctrl[0]=0. On rise → RAMP, with ctrl[0]=1 from the next cycle. Enabling therefore aligns with a period start; the first pulse occurs at the following rise.
  - RAMP (2): ctrl[0]=1. In each update slot: timer_val←tgt_timer; delay_time steps toward tgt_delay by step.
    - Arithmetic uses 17-bit unsigned difference. If |tgt_delay−delay_time| ≤ step, or step=0, then delay_time←tgt_delay.
    - No overshoot, no wrap. Ramping down is allowed.
    - When delay_time==tgt_delay after the update → RUN.
  - RUN (3): ctrl[0]=1. In each update slot, timer_val/delay_time track the targets with the same step rule. ramp_done=1 only while delay_time==tgt_delay.
  - DRAIN (4): entered from ARM/RAMP/RUN when stop=1.
    - From ARM → IDLE directly.
    - Otherwise ctrl[0] stays 1 until the next fall, then ctrl[0]←0 and → IDLE. This lets opm finish the current half-period pulse.
  - FAULT (5): ctrl[0]=0 in the same cycle the fault is registered; no drain. flt=1.
    - Leaves to IDLE only on flt_clr=1 with fault_in=0 and start=0.
    - flt_clr under any other condition is ignored.
- Fault sources, checked in every state except IDLE/FAULT:
  - fault_in=1 → FAULT, flt_code=01.
  - fault_in=1 in IDLE → FAULT also.
  - Watchdog: counter runs in RAMP/RUN/DRAIN and clears on any rise or fall. Reaching WDOG_CYC−1 → FAULT, flt_code=10.
- Priority in a single cycle: fault_in > watchdog > stop > edge/update. The first fault code latched is kept until cleared.
- start deasserted while running has no effect; only stop or a fault ends a run.
- stop and start both high in IDLE: remain in IDLE.
- Target changes mid-RUN take effect at the next update slot, subject to ramping.

Decomposition:
- Shared package opm_pkg: state encodings (3-bit), flt_code values, CTRL_EN bit index, TIME_60US=2400 (shared with opm).
- One sub-module, opm_ramp_step: combinational saturating step-toward-target (cur, tgt, step → next, at_tgt). Reused later for timer_val slewing.

Test Plan:
- Basic run: init_delay=100, tgt_delay=400, step=100, tgt_timer=50, 10 kHz sig_in → ctrl[0] rises 1 cycle after the first detected rise. delay_time goes 100→200→300→400 on successive update slots; ramp_done=1 from the third update.
- Ramp down, non-multiple: init_delay=500, tgt_delay=120, step=200 → 500→300→120. No value below 120 ever appears.
- Stop mid-high: stop pulse during sig_in high → ctrl[0] remains 1 until the cycle after the detected fall, then 0. State ends in IDLE (0).
- Watchdog: WDOG_CYC=1000, hold sig_in constant in RUN → ctrl[0]=0, flt=1, flt_code=10 at 1000 cycles after the last edge. flt_clr with start=1 is ignored; with start=0 → IDLE.
- Fault priority: fault_in and stop asserted in the same cycle during RAMP → FAULT, flt_code=01, ctrl[0]=0 next cycle, no drain.
- Reset mid-run: rst low during RUN → all outputs 0 immediately (async). After release, state=IDLE; with start held, ARM waits for a fresh rise.
